// File: rtl/mips.sv
// mips: multi-cycle 32-bit MIPS-I subset core with separate instruction and
// data memory ports. One FSM pass per instruction: fetch, decode, execute and,
// when needed, memory access and register write-back.
module mips (
    input  logic        IM_CLK,
    input  logic        Z_R,
    input  logic        DM_CLK,
    output logic [31:0] IM_ADDR,
    input  logic [31:0] IM_DATA,
    output logic        DM_WE,
    output logic [31:0] DM_ADDR,
    output logic [31:0] DM_WR_DATA,
    input  logic [31:0] DM_RD_DATA
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    // True for every opcode/funct this core implements; anything else is a NOP.
    function automatic logic is_supported(input logic [31:0] instr);
        logic ok;
        ok = 1'b0;
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    FN_SLL, FN_SRL, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t      state_r, next_state_s;
    logic [31:0] pc_r, ir_r, a_r, b_r, alu_out_r, mdr_r;
    logic        dm_we_r;
    logic [31:0] regs_r [32];

    logic [5:0]  op_s, funct_s;
    logic [4:0]  rt_s, rd_s, shamt_s, wb_addr_s;
    logic [31:0] sext_s, zext_s, alu_result_s, branch_target_s, jump_target_s;
    logic [31:0] rs_data_s, rt_data_s, wb_data_s;
    logic        branch_taken_s;
    logic        unused_s;

    // DM_CLK shares the IM_CLK net and carries no information of its own.
    assign unused_s = DM_CLK;

    assign op_s    = ir_r[31:26];
    assign rt_s    = ir_r[20:16];
    assign rd_s    = ir_r[15:11];
    assign shamt_s = ir_r[10:6];
    assign funct_s = ir_r[5:0];
    assign sext_s  = {{16{ir_r[15]}}, ir_r[15:0]};
    assign zext_s  = {16'h0000, ir_r[15:0]};

    // pc_r already points past the branch when EXEC runs.
    assign branch_target_s = pc_r + {sext_s[29:0], 2'b00};
    assign jump_target_s   = {pc_r[31:28], ir_r[25:0], 2'b00};
    assign branch_taken_s  = ((op_s == OP_BEQ) && (a_r == b_r)) ||
                             ((op_s == OP_BNE) && (a_r != b_r));

    // Register 0 reads as zero regardless of array contents.
    assign rs_data_s = (IM_DATA[25:21] == 5'd0) ? 32'h0000_0000 : regs_r[IM_DATA[25:21]];
    assign rt_data_s = (IM_DATA[20:16] == 5'd0) ? 32'h0000_0000 : regs_r[IM_DATA[20:16]];

    assign wb_addr_s = (op_s == OP_RTYPE) ? rd_s : rt_s;
    assign wb_data_s = (op_s == OP_LW) ? mdr_r : alu_out_r;

    assign IM_ADDR    = pc_r;
    assign DM_ADDR    = alu_out_r;
    assign DM_WR_DATA = b_r;
    assign DM_WE      = dm_we_r;

    // ALU: result for R-type, I-type ALU ops and load/store effective address.
    always_comb begin
        alu_result_s = 32'h0000_0000;
        case (op_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_ADD, FN_ADDU: alu_result_s = a_r + b_r;
                    FN_SUB, FN_SUBU: alu_result_s = a_r - b_r;
                    FN_AND:          alu_result_s = a_r & b_r;
                    FN_OR:           alu_result_s = a_r | b_r;
                    FN_XOR:          alu_result_s = a_r ^ b_r;
                    FN_NOR:          alu_result_s = ~(a_r | b_r);
                    FN_SLT:          alu_result_s = ($signed(a_r) < $signed(b_r)) ? 32'd1 : 32'd0;
                    FN_SLTU:         alu_result_s = (a_r < b_r) ? 32'd1 : 32'd0;
                    FN_SLL:          alu_result_s = b_r << shamt_s;
                    FN_SRL:          alu_result_s = b_r >> shamt_s;
                    default:         alu_result_s = 32'h0000_0000;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_result_s = a_r + sext_s;
            OP_SLTI: alu_result_s = ($signed(a_r) < $signed(sext_s)) ? 32'd1 : 32'd0;
            OP_ANDI: alu_result_s = a_r & zext_s;
            OP_ORI:  alu_result_s = a_r | zext_s;
            OP_XORI: alu_result_s = a_r ^ zext_s;
            OP_LUI:  alu_result_s = {ir_r[15:0], 16'h0000};
            default: alu_result_s = 32'h0000_0000;
        endcase
    end

    // FSM next-state selection.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FETCH: next_state_s = DECODE;
            DECODE: begin
                if (is_supported(IM_DATA)) begin
                    next_state_s = EXEC;
                end else begin
                    next_state_s = FETCH;
                end
            end
            EXEC: begin
                case (op_s)
                    OP_RTYPE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI: next_state_s = WB;
                    OP_LW, OP_SW:            next_state_s = MEM;
                    default:                 next_state_s = FETCH;
                endcase
            end
            MEM: begin
                if (op_s == OP_LW) begin
                    next_state_s = WB;
                end else begin
                    next_state_s = FETCH;
                end
            end
            WB:      next_state_s = FETCH;
            default: next_state_s = FETCH;
        endcase
    end

    // FSM state register.
    always_ff @(posedge IM_CLK or negedge Z_R) begin
        if (!Z_R) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath registers; the store strobe is raised for the MEM cycle only.
    always_ff @(posedge IM_CLK or negedge Z_R) begin
        if (!Z_R) begin
            pc_r      <= 32'h0000_0000;
            ir_r      <= 32'h0000_0000;
            a_r       <= 32'h0000_0000;
            b_r       <= 32'h0000_0000;
            alu_out_r <= 32'h0000_0000;
            mdr_r     <= 32'h0000_0000;
            dm_we_r   <= 1'b0;
        end else begin
            dm_we_r <= 1'b0;
            case (state_r)
                FETCH: pc_r <= pc_r + 32'd4;
                DECODE: begin
                    ir_r <= IM_DATA;
                    a_r  <= rs_data_s;
                    b_r  <= rt_data_s;
                end
                EXEC: begin
                    alu_out_r <= alu_result_s;
                    if (branch_taken_s) begin
                        pc_r <= branch_target_s;
                    end else if (op_s == OP_J) begin
                        pc_r <= jump_target_s;
                    end
                    if (op_s == OP_SW) begin
                        dm_we_r <= 1'b1;
                    end
                end
                MEM: begin
                    if (op_s == OP_LW) begin
                        mdr_r <= DM_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file: cleared on reset, written in WB, register 0 never written.
    always_ff @(posedge IM_CLK or negedge Z_R) begin
        if (!Z_R) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else if ((state_r == WB) && (wb_addr_s != 5'd0)) begin
            regs_r[wb_addr_s] <= wb_data_s;
        end
    end

endmodule

// File: tb/tb_mips.sv
// tb_mips: drives mips with a directed program, random programs checked
// cycle-by-cycle against an instruction-level reference model, and a reset
// asserted during a store.
module tb_mips;

    localparam int MAXC = 1024;

    logic        IM_CLK = 1'b0;
    logic        Z_R = 1'b0;
    logic [31:0] IM_ADDR, IM_DATA, DM_ADDR, DM_WR_DATA, DM_RD_DATA;
    logic        DM_WE;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [128];
    logic [31:0] dmem [64];
    logic [63:0] store_log [$];

    bit          exp_fetch [MAXC];
    logic [31:0] exp_pc    [MAXC];
    bit          exp_we    [MAXC];
    logic [31:0] exp_addr  [MAXC];
    logic [31:0] exp_data  [MAXC];
    logic [31:0] act_pc    [MAXC];
    bit          act_we    [MAXC];
    int          log_base;

    always #5 IM_CLK = ~IM_CLK;

    mips dut (
        .IM_CLK     (IM_CLK),
        .Z_R        (Z_R),
        .DM_CLK     (IM_CLK),
        .IM_ADDR    (IM_ADDR),
        .IM_DATA    (IM_DATA),
        .DM_WE      (DM_WE),
        .DM_ADDR    (DM_ADDR),
        .DM_WR_DATA (DM_WR_DATA),
        .DM_RD_DATA (DM_RD_DATA)
    );

    // Synchronous instruction memory, combinational-read data memory.
    always @(posedge IM_CLK) IM_DATA <= imem[IM_ADDR[8:2]];
    assign DM_RD_DATA = dmem[DM_ADDR[7:2]];

    always @(posedge IM_CLK) begin
        if (DM_WE) begin
            dmem[DM_ADDR[7:2]] = DM_WR_DATA;
            store_log.push_back({DM_ADDR, DM_WR_DATA});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Instruction-level interpreter: predicts fetch address per fetch cycle and
    // each store (cycle, address, data) from the ISA rules and cycle counts.
    task automatic build_model(input int ncyc);
        logic [31:0] r [32];
        logic [31:0] md [64];
        logic [31:0] pc, npc, ins, a, b, se, ze, v, ea;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, wi;
        bit          wr;
        int          cyc, len;
        for (int k = 0; k < MAXC; k++) begin
            exp_fetch[k] = 1'b0;
            exp_we[k]    = 1'b0;
        end
        for (int i = 0; i < 32; i++) r[i] = 32'h0;
        for (int i = 0; i < 64; i++) md[i] = dmem[i];
        pc = 32'h0;
        cyc = 0;
        while (cyc < ncyc) begin
            ins = imem[pc[8:2]];
            exp_fetch[cyc] = 1'b1;
            exp_pc[cyc] = pc;
            op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
            rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
            se = {{16{ins[15]}}, ins[15:0]};
            ze = {16'h0, ins[15:0]};
            a = r[rs]; b = r[rt];
            ea = a + se;
            npc = pc + 32'd4;
            len = 2; wr = 1'b0; wi = rt; v = 32'h0;
            case (op)
                6'h00: begin
                    len = 4; wr = 1'b1; wi = rd;
                    case (fn)
                        6'h20, 6'h21: v = a + b;
                        6'h22, 6'h23: v = a - b;
                        6'h24: v = a & b;
                        6'h25: v = a | b;
                        6'h26: v = a ^ b;
                        6'h27: v = ~(a | b);
                        6'h2a: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        6'h2b: v = (a < b) ? 32'd1 : 32'd0;
                        6'h00: v = b << sh;
                        6'h02: v = b >> sh;
                        default: begin len = 2; wr = 1'b0; end
                    endcase
                end
                6'h08, 6'h09: begin len = 4; wr = 1'b1; v = a + se; end
                6'h0a: begin len = 4; wr = 1'b1; v = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
                6'h0c: begin len = 4; wr = 1'b1; v = a & ze; end
                6'h0d: begin len = 4; wr = 1'b1; v = a | ze; end
                6'h0e: begin len = 4; wr = 1'b1; v = a ^ ze; end
                6'h0f: begin len = 4; wr = 1'b1; v = {ins[15:0], 16'h0}; end
                6'h23: begin len = 5; wr = 1'b1; v = md[ea[7:2]]; end
                6'h2b: begin
                    len = 4;
                    if (cyc + 3 < ncyc) begin
                        exp_we[cyc + 3]   = 1'b1;
                        exp_addr[cyc + 3] = ea;
                        exp_data[cyc + 3] = b;
                    end
                    md[ea[7:2]] = b;
                end
                6'h04: begin len = 3; if (a == b) npc = npc + (se << 2); end
                6'h05: begin len = 3; if (a != b) npc = npc + (se << 2); end
                6'h02: begin len = 3; npc = {npc[31:28], ins[25:0], 2'b00}; end
                default: len = 2;
            endcase
            if (wr && (wi != 5'd0)) r[wi] = v;
            pc = npc;
            cyc += len;
        end
    endtask

    // Reset, check reset outputs, release, then compare every cycle to the model.
    task automatic run_program(input int ncyc);
        Z_R = 1'b0;
        @(negedge IM_CLK); #1;
        check_eq("rst_im_addr", IM_ADDR, 32'h0);
        check_eq("rst_dm_we", {31'b0, DM_WE}, 32'h0);
        check_eq("rst_dm_addr", DM_ADDR, 32'h0);
        check_eq("rst_dm_wr_data", DM_WR_DATA, 32'h0);
        build_model(ncyc);
        log_base = store_log.size();
        @(negedge IM_CLK);
        Z_R = 1'b1;
        #1;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) begin
                @(negedge IM_CLK); #1;
            end
            act_pc[k] = IM_ADDR;
            act_we[k] = DM_WE;
            check_eq($sformatf("we@%0d", k), {31'b0, DM_WE}, {31'b0, exp_we[k]});
            if (exp_we[k]) begin
                check_eq($sformatf("st_addr@%0d", k), DM_ADDR, exp_addr[k]);
                check_eq($sformatf("st_data@%0d", k), DM_WR_DATA, exp_data[k]);
            end
            if (exp_fetch[k]) begin
                check_eq($sformatf("fetch@%0d", k), IM_ADDR, exp_pc[k]);
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int          sel;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn, op;
        logic [15:0] imm;
        int          off;
        sel = $urandom_range(0, 15);
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        sh  = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        case (sel)
            0, 1, 2, 3: begin
                case ($urandom_range(0, 12))
                    0: fn = 6'h20;  1: fn = 6'h21;  2: fn = 6'h22;  3: fn = 6'h23;
                    4: fn = 6'h24;  5: fn = 6'h25;  6: fn = 6'h26;  7: fn = 6'h27;
                    8: fn = 6'h2a;  9: fn = 6'h2b; 10: fn = 6'h00; 11: fn = 6'h02;
                    default: fn = 6'($urandom);
                endcase
                return {6'h00, rs, rt, rd, sh, fn};
            end
            4, 5, 6: begin
                case ($urandom_range(0, 6))
                    0: op = 6'h08; 1: op = 6'h09; 2: op = 6'h0a; 3: op = 6'h0c;
                    4: op = 6'h0d; 5: op = 6'h0e; default: op = 6'h0f;
                endcase
                return {op, rs, rt, imm};
            end
            7, 8:       return {6'h23, rs, rt, imm};
            9, 10, 11:  return {6'h2b, rs, rt, imm};
            12: begin
                off = $urandom_range(0, 8) - 4;
                op = ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05;
                return {op, rs, rt, off[15:0]};
            end
            13:      return {6'h02, 26'($urandom_range(0, 127))};
            14:      return 32'($urandom);
            default: return {6'h0f, 5'd0, rt, imm};
        endcase
    endfunction

    initial begin
        int n;
        // Directed program.
        for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0000;
        for (int i = 0; i < 64; i++)  dmem[i] = 32'($urandom);
        dmem[1] = 32'h1234_ABCD;
        imem[0]  = 32'h2001_0005; // addi $1,$0,5
        imem[1]  = 32'h2002_0007; // addi $2,$0,7
        imem[2]  = 32'h0022_1820; // add  $3,$1,$2
        imem[3]  = 32'hAC03_0008; // sw   $3,8($0)
        imem[4]  = 32'h8C04_0004; // lw   $4,4($0)
        imem[5]  = 32'hAC04_000C; // sw   $4,12($0)
        imem[6]  = 32'h1000_0002; // beq  $0,$0,+2 -> 0x24
        imem[7]  = 32'h2007_0001; // skipped
        imem[8]  = 32'h2007_0001; // skipped
        imem[9]  = 32'h1400_0003; // bne  $0,$0,+3 (not taken)
        imem[10] = 32'h0800_0040; // j    0x100
        imem[64] = 32'h2000_0009; // addi $0,$0,9
        imem[65] = 32'hAC00_0000; // sw   $0,0($0)
        imem[66] = 32'h2006_FFFE; // addi $6,$0,-2
        imem[67] = 32'h28C5_FFFF; // slti $5,$6,-1
        imem[68] = 32'hAC05_0014; // sw   $5,20($0)
        imem[69] = 32'h0800_0045; // j    self
        run_program(70);
        check_eq("first_fetch_c0", act_pc[0], 32'h0);
        check_eq("second_fetch_c4", act_pc[4], 32'h4);
        check_eq("sw1_we_c15", {31'b0, act_we[15]}, 32'h1);
        check_eq("lw_sw_we_c24", {31'b0, act_we[24]}, 32'h1);
        check_eq("lw_sw_we_c23", {31'b0, act_we[23]}, 32'h0);
        check_eq("beq_target_c28", act_pc[28], 32'h24);
        check_eq("bne_fall_c31", act_pc[31], 32'h28);
        check_eq("j_target_c34", act_pc[34], 32'h100);
        check_eq("store_count", 32'(store_log.size() - log_base), 32'd4);
        if (store_log.size() - log_base >= 4) begin
            check_eq("add_st_addr", store_log[log_base][63:32], 32'd8);
            check_eq("add_st_data", store_log[log_base][31:0], 32'd12);
            check_eq("lw_st_addr", store_log[log_base + 1][63:32], 32'd12);
            check_eq("lw_st_data", store_log[log_base + 1][31:0], 32'h1234_ABCD);
            check_eq("r0_st_data", store_log[log_base + 2][31:0], 32'h0);
            check_eq("slti_st_addr", store_log[log_base + 3][63:32], 32'd20);
            check_eq("slti_st_data", store_log[log_base + 3][31:0], 32'd1);
        end

        // Random programs against the reference model.
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 128; i++) imem[i] = rand_instr();
            for (int i = 0; i < 64; i++)  dmem[i] = 32'($urandom);
            run_program(400);
        end

        // Reset asserted during the MEM cycle of a store.
        for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0000;
        imem[0] = 32'h2001_0003; // addi $1,$0,3
        imem[1] = 32'hAC01_0010; // sw   $1,16($0)
        imem[2] = 32'h0800_0002; // j    self
        dmem[4] = 32'hDEAD_BEEF;
        run_program(7);
        @(negedge IM_CLK); #1;
        check_eq("mem_we_before_rst", {31'b0, DM_WE}, 32'h1);
        n = store_log.size();
        Z_R = 1'b0;
        #1;
        check_eq("we_async_drop", {31'b0, DM_WE}, 32'h0);
        check_eq("addr_async_clear", DM_ADDR, 32'h0);
        repeat (3) @(posedge IM_CLK);
        #1;
        check_eq("no_store_logged", 32'(store_log.size()), 32'(n));
        check_eq("dmem_untouched", dmem[4], 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
